hub75_column_loader: RTL and testbench

HUB75_COLUMN_LOADER -- requirements
Module: hub75_column_loader

---
 rtl/hub75_pkg.sv | 47 ++++
 rtl/hub75_fetch_pipe.sv | 31 +++
 rtl/hub75_column_loader.sv | 170 +++++++++++++++++
 tb/tb_hub75_column_loader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 column loader: pixel layout,
// bit-plane column storage, fetch pipeline tag and address sizing.
package hub75_pkg;

  localparam int R_PLANE0   = 0;
  localparam int G_PLANE0   = 3;
  localparam int B_PLANE0   = 6;
  localparam int NUM_PLANES = 9;
  localparam int PANEL_COLS = 64;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } pixel_t;

  typedef logic [NUM_PLANES-1:0][PANEL_COLS-1:0] plane_col_t;

  typedef struct packed {
    logic       valid;
    logic       half;
    logic [5:0] col;
  } fetch_tag_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PRESENT
  } state_t;

  function automatic int addr_width(input int rot_res);
    return $clog2(rot_res) + 12;
  endfunction

  // Splits one RGB333 pixel into its nine bit-plane bits.
  function automatic logic [NUM_PLANES-1:0] pixel_to_planes(input pixel_t px);
    logic [NUM_PLANES-1:0] planes;
    planes = '0;
    for (int i = 0; i < 3; i++) begin
      planes[R_PLANE0+i] = px.r[i];
      planes[G_PLANE0+i] = px.g[i];
      planes[B_PLANE0+i] = px.b[i];
    end
    return planes;
  endfunction

endpackage

// File: rtl/hub75_fetch_pipe.sv
// Delays the fetch tag so it lines up with the word the frame memory
// returns for the same address.
module hub75_fetch_pipe
  import hub75_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  fetch_tag_t tag_in,
  output fetch_tag_t tag_out
);

  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
    fetch_tag_t q;
    if (gi == 0) begin : g_first
      always_ff @(posedge clk_in) begin
        if (rst_in) q <= '0;
        else        q <= tag_in;
      end
    end else begin : g_next
      always_ff @(posedge clk_in) begin
        if (rst_in) q <= '0;
        else        q <= g_stage[gi-1].q;
      end
    end
  end

  assign tag_out = g_stage[LATENCY-1].q;

endmodule

// File: rtl/hub75_column_loader.sv
// Loads one angular slice from frame memory, two panel rows at a time, into
// bit-plane column registers and hands them to the HUB75 output stage.
module hub75_column_loader
  import hub75_pkg::*;
#(
  parameter  int ROTATIONAL_RES = 180,
  parameter  int NUM_COLS       = 64,
  parameter  int NUM_ROWS       = 64,
  parameter  int SCAN_RATE      = 32,
  parameter  int BRAM_LATENCY   = 2,
  localparam int THETA_W        = $clog2(ROTATIONAL_RES),
  localparam int ADDR_W         = addr_width(ROTATIONAL_RES),
  localparam int ROW_IDX_W      = $clog2(SCAN_RATE)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 slice_start,
  input  logic [THETA_W-1:0]   theta_in,
  output logic [ADDR_W-1:0]    addr_out,
  input  logic [8:0]           rd_data_in,
  output plane_col_t           column_data0,
  output plane_col_t           column_data1,
  output logic [ROW_IDX_W-1:0] col_index,
  output logic                 tvalid,
  output logic                 tlast,
  input  logic                 tready,
  output logic                 busy
);

  localparam int COL_W       = $clog2(NUM_COLS);
  localparam int ROW_W       = $clog2(NUM_ROWS);
  localparam int FETCH_WORDS = 2 * NUM_COLS;
  localparam int CNT_W       = $clog2(FETCH_WORDS) + 1;

  state_t                 state_q, state_d;
  logic [THETA_W-1:0]     theta_q, theta_d;
  logic [THETA_W-1:0]     pend_theta_q, pend_theta_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [ROW_IDX_W-1:0]   row_q, row_d;
  logic [CNT_W-1:0]       issue_cnt_q, issue_cnt_d;
  logic [ADDR_W-1:0]      addr_q;
  fetch_tag_t             issue_tag_q, wr_tag;
  plane_col_t             col0_q, col1_q;

  logic                   issuing, issue_half, transfer, last_row, last_write;
  logic [COL_W-1:0]       issue_col;
  logic [ROW_W-1:0]       issue_row;
  logic [THETA_W-1:0]     theta_clamped;
  logic [NUM_PLANES-1:0]  wr_planes;

  assign theta_clamped = (32'(theta_in) >= 32'(ROTATIONAL_RES))
                         ? THETA_W'(ROTATIONAL_RES - 1) : theta_in;

  assign issuing    = (state_q == ST_FETCH) && (issue_cnt_q < CNT_W'(FETCH_WORDS));
  assign issue_half = issue_cnt_q[COL_W];
  assign issue_col  = issue_cnt_q[COL_W-1:0];
  assign issue_row  = ROW_W'(row_q) + (issue_half ? ROW_W'(SCAN_RATE) : ROW_W'(0));

  assign transfer   = (state_q == ST_PRESENT) && tready;
  assign last_row   = (row_q == ROW_IDX_W'(SCAN_RATE - 1));
  // The slice row is complete once the final lower-half word has been tagged back.
  assign last_write = (state_q == ST_FETCH) && wr_tag.valid && wr_tag.half
                      && (wr_tag.col == COL_W'(NUM_COLS - 1));

  always_comb begin
    state_d      = state_q;
    theta_d      = theta_q;
    row_d        = row_q;
    pend_valid_d = pend_valid_q;
    pend_theta_d = pend_theta_q;
    issue_cnt_d  = issuing ? issue_cnt_q + CNT_W'(1) : issue_cnt_q;

    if (slice_start && (state_q != ST_IDLE)) begin
      pend_valid_d = 1'b1;
      pend_theta_d = theta_clamped;
    end

    case (state_q)
      ST_IDLE: begin
        if (slice_start) begin
          state_d     = ST_FETCH;
          theta_d     = theta_clamped;
          row_d       = '0;
          issue_cnt_d = '0;
        end
      end
      ST_FETCH: begin
        if (last_write) state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (transfer) begin
          issue_cnt_d = '0;
          if (!last_row) begin
            row_d   = row_q + ROW_IDX_W'(1);
            state_d = ST_FETCH;
          end else begin
            row_d = '0;
            // A request arriving with the final transfer beats an older pending one.
            if (slice_start) begin
              state_d      = ST_FETCH;
              theta_d      = theta_clamped;
              pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
              state_d      = ST_FETCH;
              theta_d      = pend_theta_q;
              pend_valid_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      theta_q      <= '0;
      row_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_theta_q <= '0;
      issue_cnt_q  <= '0;
      addr_q       <= '0;
      issue_tag_q  <= '0;
    end else begin
      state_q      <= state_d;
      theta_q      <= theta_d;
      row_q        <= row_d;
      pend_valid_q <= pend_valid_d;
      pend_theta_q <= pend_theta_d;
      issue_cnt_q  <= issue_cnt_d;
      if (issuing) addr_q <= {theta_q, issue_row, issue_col};
      issue_tag_q  <= '{valid: issuing, half: issue_half, col: issue_col};
    end
  end

  hub75_fetch_pipe #(
    .LATENCY(BRAM_LATENCY)
  ) u_fetch_pipe (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .tag_in (issue_tag_q),
    .tag_out(wr_tag)
  );

  assign wr_planes = pixel_to_planes(pixel_t'(rd_data_in));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      col0_q <= '0;
      col1_q <= '0;
    end else if ((state_q == ST_FETCH) && wr_tag.valid) begin
      for (int p = 0; p < NUM_PLANES; p++) begin
        if (wr_tag.half) col1_q[p][wr_tag.col] <= wr_planes[p];
        else             col0_q[p][wr_tag.col] <= wr_planes[p];
      end
    end
  end

  assign addr_out     = addr_q;
  assign column_data0 = col0_q;
  assign column_data1 = col1_q;
  assign col_index    = row_q;
  assign tvalid       = (state_q == ST_PRESENT);
  assign tlast        = tvalid && last_row;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hub75_column_loader.sv
// Scoreboard bench for hub75_column_loader: expected row pairs are queued when
// a slice is requested and checked against each tvalid&tready transfer.
module tb_hub75_column_loader;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic              slice_start = 1'b0;
  logic [7:0]        theta_in = '0;
  logic [19:0]       addr_out;
  logic [8:0]        rd_data_in = '0;
  logic [8:0][63:0]  column_data0, column_data1;
  logic [4:0]        col_index;
  logic              tvalid, tlast, busy;
  logic              tready = 1'b0;

  always #5 clk_in = ~clk_in;

  hub75_column_loader dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .slice_start (slice_start),
    .theta_in    (theta_in),
    .addr_out    (addr_out),
    .rd_data_in  (rd_data_in),
    .column_data0(column_data0),
    .column_data1(column_data1),
    .col_index   (col_index),
    .tvalid      (tvalid),
    .tlast       (tlast),
    .tready      (tready),
    .busy        (busy)
  );

  typedef struct {
    logic [4:0]       idx;
    logic             last;
    logic [8:0][63:0] d0;
    logic [8:0][63:0] d1;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0, bad = 0;
  int   mode = 0, xfers = 0, seen7 = 0, seen9 = 0;
  logic [8:0] rd_p1 = '0;

  task automatic chk(input string tag, input logic [575:0] got, input logic [575:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame-memory contents: 0 plain ramp, 1 ramp offset by theta, 2 single pixel.
  function automatic logic [8:0] pix_of(input int th, input int row, input int col);
    if (mode == 0)      return 9'((row * 64 + col) % 512);
    else if (mode == 1) return 9'((row * 64 + col + th * 37) % 512);
    else                return (row == 40 && col == 10) ? 9'h1C5 : 9'h000;
  endfunction

  function automatic logic plane_bit(input logic [8:0] px, input int p);
    logic [2:0] rr, gg, bb;
    rr = px[8:6];
    gg = px[5:3];
    bb = px[2:0];
    if (p < 3)      return rr[p];
    else if (p < 6) return gg[p-3];
    else            return bb[p-6];
  endfunction

  always @(posedge clk_in) begin
    rd_p1      <= pix_of(int'(addr_out[19:12]), int'(addr_out[11:6]), int'(addr_out[5:0]));
    rd_data_in <= rd_p1;
  end

  always @(negedge clk_in) begin
    if (addr_out[19:12] == 8'd7) seen7++;
    if (addr_out[19:12] == 8'd9) seen9++;
  end

  always @(negedge clk_in) begin
    if (!rst_in && tvalid && tready) begin
      xfers++;
      chk("sb_has_entry", 576'(sb.size() != 0), 576'(1));
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("col_index", 576'(col_index), 576'(mon_e.idx));
        chk("tlast", 576'(tlast), 576'(mon_e.last));
        chk("column_data0", 576'(column_data0), 576'(mon_e.d0));
        chk("column_data1", 576'(column_data1), 576'(mon_e.d1));
      end
      $display("xfer %0d idx=%0d last=%0b", xfers, col_index, tlast);
    end
  end

  task automatic push_slice(input int th);
    exp_t e;
    for (int r = 0; r < 32; r++) begin
      e.idx  = 5'(r);
      e.last = (r == 31);
      for (int c = 0; c < 64; c++) begin
        for (int p = 0; p < 9; p++) begin
          e.d0[p][c] = plane_bit(pix_of(th, r, c), p);
          e.d1[p][c] = plane_bit(pix_of(th, r + 32, c), p);
        end
      end
      sb.push_back(e);
    end
  endtask

  task automatic start(input int th);
    slice_start = 1'b1;
    theta_in    = 8'(th);
    @(posedge clk_in); #1;
    slice_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk_in); #1;
      n++;
    end
    chk("idle_timeout", 576'(busy), 576'(0));
  endtask

  task automatic wait_tvalid(input int budget);
    int n = 0;
    while (!tvalid && n < budget) begin
      @(posedge clk_in); #1;
      n++;
    end
    chk("tvalid_timeout", 576'(tvalid), 576'(1));
  endtask

  task automatic check_cleared(input string sfx);
    chk({"tvalid_", sfx}, 576'(tvalid), 576'(0));
    chk({"tlast_", sfx}, 576'(tlast), 576'(0));
    chk({"busy_", sfx}, 576'(busy), 576'(0));
    chk({"col_index_", sfx}, 576'(col_index), 576'(0));
    chk({"addr_out_", sfx}, 576'(addr_out), 576'(0));
    chk({"data0_", sfx}, 576'(column_data0), 576'(0));
    chk({"data1_", sfx}, 576'(column_data1), 576'(0));
  endtask

  initial begin
    int n;
    int stable;
    logic [8:0][63:0] s0, s1;
    logic [4:0] si;
    logic sl;

    repeat (3) @(posedge clk_in);
    #1;
    check_cleared("reset");
    rst_in = 1'b0;
    @(posedge clk_in); #1;

    // Ramp image, free-running sink, first-word latency
    mode = 0;
    tready = 1'b1;
    push_slice(5);
    start(5);
    n = 0;
    while (!tvalid && n < 200) begin
      @(posedge clk_in); #1;
      n++;
    end
    chk("first_tvalid_latency", 576'(n), 576'(131));
    wait_idle(4500);
    chk("xfers_slice1", 576'(xfers), 576'(32));

    // Back-pressure: outputs frozen while tready is low
    mode = 1;
    tready = 1'b0;
    push_slice(11);
    start(11);
    wait_tvalid(300);
    s0 = column_data0; s1 = column_data1; si = col_index; sl = tlast;
    stable = 0;
    repeat (50) begin
      @(posedge clk_in); #1;
      if (tvalid && column_data0 == s0 && column_data1 == s1 && col_index == si && tlast == sl)
        stable++;
    end
    chk("stall_stable_cycles", 576'(stable), 576'(50));
    tready = 1'b1;
    wait_idle(4500);

    // Pending requests while busy: newest theta wins
    seen7 = 0;
    seen9 = 0;
    push_slice(3);
    start(3);
    repeat (10) @(posedge clk_in);
    #1;
    start(7);
    repeat (10) @(posedge clk_in);
    #1;
    push_slice(9);
    start(9);
    wait_idle(9000);
    chk("theta7_never_fetched", 576'(seen7), 576'(0));
    chk("theta9_fetched", 576'(seen9 != 0), 576'(1));

    // Request coincident with the final transfer, out-of-range theta clamped
    push_slice(20);
    start(20);
    n = 0;
    while (!(tvalid && tlast) && n < 5000) begin
      @(posedge clk_in); #1;
      n++;
    end
    chk("found_tlast", 576'(tvalid && tlast), 576'(1));
    slice_start = 1'b1;
    theta_in    = 8'd200;
    push_slice(179);
    @(posedge clk_in); #1;
    slice_start = 1'b0;
    chk("busy_after_final", 576'(busy), 576'(1));
    chk("restart_row", 576'(col_index), 576'(0));
    @(posedge clk_in); #1;
    chk("restart_addr", 576'(addr_out), 576'({8'd179, 6'd0, 6'd0}));
    wait_idle(4500);

    // Single lit pixel at row 40, column 10
    mode = 2;
    push_slice(2);
    start(2);
    wait_idle(4500);

    // Reset in the middle of a fetch, then a fresh slice
    mode = 0;
    start(4);
    repeat (60) @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    check_cleared("midreset");
    repeat (5) @(posedge clk_in);
    #1;
    chk("late_data0_ignored", 576'(column_data0), 576'(0));
    chk("late_data1_ignored", 576'(column_data1), 576'(0));
    push_slice(6);
    start(6);
    wait_idle(4500);

    chk("sb_drained", 576'(sb.size()), 576'(0));
    chk("total_xfers", 576'(xfers), 576'(256));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
